scoreboard_forward_unit: RTL and testbench



---
 rtl/scoreboard_forward_unit_pkg.sv | 25 ++
 rtl/scoreboard_forward_unit_operand_resolver.sv | 67 ++++++
 rtl/scoreboard_forward_unit.sv | 114 +++++++++++
 tb/tb_scoreboard_forward_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_forward_unit_pkg.sv
// scoreboard_forward_unit_pkg: pipeline stage indices and the shadow slot record shared by the
// decoder, the pipeline controller and the forwarding unit.
package scoreboard_forward_unit_pkg;

  localparam int STAGE_D = 0;
  localparam int STAGE_E = 1;
  localparam int STAGE_M = 2;
  localparam int STAGE_W = 3;

  localparam int PIPE_REG_AW = 5;
  localparam int PIPE_SW     = $clog2(STAGE_W + 2);

  // Slot record at the standard pipeline widths; the unit derives a parametrised twin from it.
  typedef struct packed {
    logic                   valid;
    logic [PIPE_REG_AW-1:0] dest;
    logic [PIPE_SW-1:0]     ready;
  } slotRec_t;

  // Results claiming to be ready outside E..last tracked stage are treated as late as possible.
  function automatic int clampReady(input int ready, input int stages);
    return (ready < 1 || ready > stages) ? stages : ready;
  endfunction

endpackage

// File: rtl/scoreboard_forward_unit_operand_resolver.sv
// scoreboard_forward_unit_operand_resolver: one decode operand port; picks the youngest matching
// in-flight slot and decides between forwarding, register file data or a hazard.
module scoreboard_forward_unit_operand_resolver #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int SW     = 3
) (
  input  logic [REG_AW-1:0]        addr,
  input  logic [SW-1:0]            need,
  input  logic [DATA_W-1:0]        grf,
  input  logic [STAGES-1:0]        slotValid,
  input  logic [STAGES*REG_AW-1:0] slotDest,
  input  logic [STAGES*SW-1:0]     slotReady,
  input  logic [STAGES*DATA_W-1:0] slotValue,
  input  logic [STAGES-1:0]        slotValueValid,
  output logic [DATA_W-1:0]        value,
  output logic                     hazard,
  output logic                     fwdHit
);

  logic              hit;
  logic              hitValueValid;
  logic [DATA_W-1:0] hitValue;
  logic [SW-1:0]     hitReady;
  logic [SW:0]       hitDistance;
  logic [SW:0]       arrival;

  always_comb begin
    // NOTE: every variable gets a default before the conditional logic, so no path leaves one unassigned and no latch is inferred.
    hit           = 1'b0;
    hitValueValid = 1'b0;
    hitValue      = '0;
    hitReady      = '0;
    hitDistance   = '0;
    // Scan oldest to youngest so a younger duplicate destination overrides an older one.
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (slotValid[i] && slotDest[i*REG_AW +: REG_AW] == addr) begin
        hit           = 1'b1;
        hitValueValid = slotValueValid[i];
        hitValue      = slotValue[i*DATA_W +: DATA_W];
        hitReady      = slotReady[i*SW +: SW];
        hitDistance   = (SW+1)'(i + 1);
      end
    end
  end

  // Stage the producer will have reached when this operand is consumed.
  assign arrival = hitDistance + {1'b0, need};

  always_comb begin
    value  = grf;
    hazard = 1'b0;
    fwdHit = 1'b0;
    if (addr == '0) begin
      value = '0;
    end else if (hit) begin
      if (hitValueValid) begin
        value  = hitValue;
        fwdHit = 1'b1;
      end else begin
        hazard = arrival < {1'b0, hitReady};
      end
    end
  end

endmodule

// File: rtl/scoreboard_forward_unit.sv
// scoreboard_forward_unit: decode-stage hazard and forwarding unit shadowing STAGES in-flight results.
// Define SCOREBOARD_PERF_EN to add saturating stall-cycle and forward-hit counters.
module scoreboard_forward_unit
  import scoreboard_forward_unit_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  REG_AW     = 5,
  parameter int  STAGES     = 3,
  parameter int  READ_PORTS = 2,
  localparam int SW         = $clog2(STAGES + 2)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [REG_AW-1:0]            issue_dest,
  input  logic [SW-1:0]                issue_ready,
  input  logic [READ_PORTS*REG_AW-1:0] rd_addr,
  input  logic [READ_PORTS*SW-1:0]     rd_need,
  input  logic [READ_PORTS*DATA_W-1:0] rd_grf,
  input  logic [STAGES*DATA_W-1:0]     slot_value,
  input  logic [STAGES-1:0]            slot_value_valid,
  input  logic                         hold,
  input  logic                         flush,
  output logic [READ_PORTS*DATA_W-1:0] rd_value,
  output logic                         stall_req,
  output logic [STAGES*REG_AW-1:0]     slot_dest
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_forward_hits
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [SW-1:0]     ready;
  } slotT;

  slotT                     slots [STAGES];
  slotT                     issueSlot;
  logic [STAGES-1:0]        slotValidVec;
  logic [STAGES*REG_AW-1:0] slotDestVec;
  logic [STAGES*SW-1:0]     slotReadyVec;
  logic [READ_PORTS-1:0]    portHazard;
  logic [READ_PORTS-1:0]    portFwd;

  for (genvar i = 0; i < STAGES; i++) begin : gSlot
    assign slotValidVec[i]                  = slots[i].valid;
    assign slotDestVec[i*REG_AW +: REG_AW]  = slots[i].dest;
    assign slotReadyVec[i*SW +: SW]         = slots[i].ready;
    assign slot_dest[i*REG_AW +: REG_AW]    = slots[i].valid ? slots[i].dest : '0;
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : gPort
    scoreboard_forward_unit_operand_resolver #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .STAGES (STAGES),
      .SW     (SW)
    ) uResolver (
      .addr           (rd_addr[p*REG_AW +: REG_AW]),
      .need           (rd_need[p*SW +: SW]),
      .grf            (rd_grf[p*DATA_W +: DATA_W]),
      .slotValid      (slotValidVec),
      .slotDest       (slotDestVec),
      .slotReady      (slotReadyVec),
      .slotValue      (slot_value),
      .slotValueValid (slot_value_valid),
      .value          (rd_value[p*DATA_W +: DATA_W]),
      .hazard         (portHazard[p]),
      .fwdHit         (portFwd[p])
    );
  end

  assign stall_req = issue_valid && !flush && (|portHazard);

  // A stalled, flushed or non-writing decode instruction enters the shadow as a bubble.
  always_comb begin
    issueSlot = '0;
    if (issue_valid && !stall_req && !flush && issue_dest != '0) begin
      issueSlot.valid = 1'b1;
      issueSlot.dest  = issue_dest;
      issueSlot.ready = SW'(clampReady(int'(issue_ready), STAGES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow is a few flops rather than a RAM, so it is reset; a stale valid bit would fabricate hazards.
      for (int i = 0; i < STAGES; i++) slots[i] <= '0;
    end else if (!hold) begin
      // NOTE: non-blocking assignments make every slot take its neighbour's pre-edge value, giving a true shift.
      for (int i = 1; i < STAGES; i++) slots[i] <= slots[i-1];
      slots[0] <= issueSlot;
    end
  end

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_forward_hits <= '0;
    end else begin
      if (stall_req && !hold && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if ((|portFwd) && perf_forward_hits != '1) perf_forward_hits <= perf_forward_hits + 32'd1;
    end
  end
`else
  logic unusedPortFwd;
  assign unusedPortFwd = ^portFwd;
`endif

endmodule

// File: tb/tb_scoreboard_forward_unit.sv
// tb_scoreboard_forward_unit: directed and randomized checks of scoreboard_forward_unit against a
// queue-based reference model of the in-flight instruction window.
module tb_scoreboard_forward_unit;
  import scoreboard_forward_unit_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int STAGES     = 3;
  localparam int READ_PORTS = 2;
  localparam int SW         = $clog2(STAGES + 2);

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         issue_valid;
  logic [REG_AW-1:0]            issue_dest;
  logic [SW-1:0]                issue_ready;
  logic [READ_PORTS*REG_AW-1:0] rd_addr;
  logic [READ_PORTS*SW-1:0]     rd_need;
  logic [READ_PORTS*DATA_W-1:0] rd_grf;
  logic [STAGES*DATA_W-1:0]     slot_value;
  logic [STAGES-1:0]            slot_value_valid;
  logic                         hold;
  logic                         flush;
  logic [READ_PORTS*DATA_W-1:0] rd_value;
  logic                         stall_req;
  logic [STAGES*REG_AW-1:0]     slot_dest;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0]                  perf_stall_cycles;
  logic [31:0]                  perf_forward_hits;
`endif

  logic [REG_AW-1:0] tAddr    [READ_PORTS];
  logic [SW-1:0]     tNeed    [READ_PORTS];
  logic [DATA_W-1:0] tGrf     [READ_PORTS];
  logic [DATA_W-1:0] tSlotVal [STAGES];

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_addr[p*REG_AW +: REG_AW] = tAddr[p];
      rd_need[p*SW +: SW]         = tNeed[p];
      rd_grf[p*DATA_W +: DATA_W]  = tGrf[p];
    end
    for (int i = 0; i < STAGES; i++) slot_value[i*DATA_W +: DATA_W] = tSlotVal[i];
  end

  scoreboard_forward_unit #(
    .DATA_W     (DATA_W),
    .REG_AW     (REG_AW),
    .STAGES     (STAGES),
    .READ_PORTS (READ_PORTS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_dest       (issue_dest),
    .issue_ready      (issue_ready),
    .rd_addr          (rd_addr),
    .rd_need          (rd_need),
    .rd_grf           (rd_grf),
    .slot_value       (slot_value),
    .slot_value_valid (slot_value_valid),
    .hold             (hold),
    .flush            (flush),
    .rd_value         (rd_value),
    .stall_req        (stall_req),
    .slot_dest        (slot_dest)
`ifdef SCOREBOARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_forward_hits (perf_forward_hits)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the in-flight window as a queue, front = youngest instruction.
  typedef struct {
    bit valid;
    int dest;
    int ready;
  } recT;

  recT model [$];
  int  errors = 0;
  int  checks = 0;
  int  mStall = 0;
  int  mFwd   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    recT bubble;
    bubble = '{valid: 1'b0, dest: 0, ready: 0};
    model.delete();
    for (int i = 0; i < STAGES; i++) model.push_back(bubble);
    mStall = 0;
    mFwd   = 0;
  endtask

  function automatic void resolve(input int p, output logic [DATA_W-1:0] v, output bit haz, output bit fwd);
    bit found;
    v     = tGrf[p];
    haz   = 1'b0;
    fwd   = 1'b0;
    found = 1'b0;
    if (tAddr[p] == '0) begin
      v = '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (!found && model[i].valid && model[i].dest == int'(tAddr[p])) begin
          found = 1'b1;
          if (slot_value_valid[i]) begin
            v   = tSlotVal[i];
            fwd = 1'b1;
          end else if ((i + 1) + int'(tNeed[p]) < model[i].ready) begin
            haz = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic bit expStall();
    logic [DATA_W-1:0] v;
    bit h, f, any;
    any = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      resolve(p, v, h, f);
      any |= h;
    end
    return issue_valid && !flush && any;
  endfunction

  function automatic logic [STAGES*REG_AW-1:0] expSlotDest();
    logic [STAGES*REG_AW-1:0] d;
    d = '0;
    for (int i = 0; i < STAGES; i++)
      if (model[i].valid) d[i*REG_AW +: REG_AW] = REG_AW'(model[i].dest);
    return d;
  endfunction

  task automatic checkAll(input string tag);
    logic [DATA_W-1:0] v;
    bit h, f;
    #1;
    for (int p = 0; p < READ_PORTS; p++) begin
      resolve(p, v, h, f);
      check($sformatf("%s.rd_value%0d", tag, p), 64'(rd_value[p*DATA_W +: DATA_W]), 64'(v));
    end
    check({tag, ".stall_req"}, 64'(stall_req), 64'(expStall()));
    check({tag, ".slot_dest"}, 64'(slot_dest), 64'(expSlotDest()));
`ifdef SCOREBOARD_PERF_EN
    check({tag, ".perf_stall"}, 64'(perf_stall_cycles), 64'(mStall));
    check({tag, ".perf_fwd"}, 64'(perf_forward_hits), 64'(mFwd));
`endif
  endtask

  task automatic tick();
    logic [DATA_W-1:0] v;
    bit h, f, st, anyFwd;
    recT r;
    st     = expStall();
    anyFwd = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      resolve(p, v, h, f);
      anyFwd |= f;
    end
    @(posedge clk);
    if (reset) begin
      clearModel();
    end else begin
      if (st && !hold) mStall++;
      if (anyFwd) mFwd++;
      if (!hold) begin
        r = '{valid: 1'b0, dest: 0, ready: 0};
        if (issue_valid && !st && !flush && issue_dest != '0) begin
          r.valid = 1'b1;
          r.dest  = int'(issue_dest);
          r.ready = (issue_ready >= 1 && int'(issue_ready) <= STAGES) ? int'(issue_ready) : STAGES;
        end
        model.push_front(r);
        void'(model.pop_back());
      end
    end
    #1;
  endtask

  task automatic setIssue(input logic valid, input int dest, input int ready);
    issue_valid = valid;
    issue_dest  = REG_AW'(dest);
    issue_ready = SW'(ready);
  endtask

  initial begin
    clearModel();
    reset            = 1'b1;
    hold             = 1'b0;
    flush            = 1'b0;
    slot_value_valid = '0;
    setIssue(1'b0, 0, 0);
    for (int p = 0; p < READ_PORTS; p++) begin
      tAddr[p] = '0;
      tNeed[p] = '0;
      tGrf[p]  = DATA_W'(32'h100 + p);
    end
    for (int i = 0; i < STAGES; i++) tSlotVal[i] = '0;
    tAddr[0] = 5'd5;
    tGrf[0]  = 32'h11;
    tick();

    // Reset state: no in-flight writers, operand comes from the register file.
    checkAll("reset");
    check("reset.rd_value0", 64'(rd_value[DATA_W-1:0]), 64'h11);
    check("reset.stall", 64'(stall_req), 64'd0);
    check("reset.slot_dest", 64'(slot_dest), 64'd0);
    reset = 1'b0;

    // ALU result forwarded from slot 0.
    setIssue(1'b1, 8, STAGE_E);
    tAddr[0] = '0;
    checkAll("aluIssue");
    tick();
    setIssue(1'b0, 0, 0);
    tAddr[0]         = 5'd8;
    tSlotVal[0]      = 32'hAB;
    slot_value_valid = 3'b001;
    checkAll("aluFwd");
    check("aluFwd.value", 64'(rd_value[DATA_W-1:0]), 64'hAB);
    check("aluFwd.stall", 64'(stall_req), 64'd0);
    tick();

    // Result ready in M, consumed in D by the next instruction: one stall cycle.
    slot_value_valid = '0;
    tAddr[0]         = '0;
    setIssue(1'b1, 9, STAGE_M);
    checkAll("loadIssue");
    tick();
    tAddr[0] = 5'd9;
    tNeed[0] = SW'(STAGE_D);
    setIssue(1'b1, 10, STAGE_E);
    checkAll("loadStall");
    check("loadStall.stall", 64'(stall_req), 64'd1);
    tick();
    checkAll("loadResume");
    check("loadResume.slot_dest", 64'(slot_dest), 64'h120);
    check("loadResume.stall", 64'(stall_req), 64'd0);
    tick();

    // Duplicate destinations: youngest wins; register 0 is always zero.
    tAddr[0] = '0;
    tNeed[0] = '0;
    setIssue(1'b1, 4, STAGE_E);
    tick();
    tick();
    setIssue(1'b0, 0, 0);
    tAddr[0]         = 5'd4;
    tSlotVal[0]      = 32'h2;
    tSlotVal[1]      = 32'h1;
    slot_value_valid = 3'b011;
    checkAll("dupDest");
    check("dupDest.value", 64'(rd_value[DATA_W-1:0]), 64'h2);
    tAddr[0] = '0;
    checkAll("zeroReg");
    check("zeroReg.value", 64'(rd_value[DATA_W-1:0]), 64'h0);
    tick();

    // Stall under hold: shadow frozen, no bubble; then flush clears the stall.
    slot_value_valid = '0;
    setIssue(1'b1, 7, STAGE_W);
    tick();
    tAddr[0] = 5'd7;
    tNeed[0] = SW'(STAGE_D);
    setIssue(1'b1, 11, STAGE_E);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkAll($sformatf("hold%0d", k));
      check($sformatf("hold%0d.stall", k), 64'(stall_req), 64'd1);
      tick();
    end
    hold  = 1'b0;
    flush = 1'b1;
    checkAll("flush");
    check("flush.stall", 64'(stall_req), 64'd0);
    tick();
    flush = 1'b0;
    checkAll("postFlush");
    tick();

    // Reset asserted in the middle of a stall takes effect before the next edge.
    tAddr[0] = '0;
    setIssue(1'b1, 12, STAGE_W);
    tick();
    tAddr[0] = 5'd12;
    setIssue(1'b1, 13, STAGE_E);
    checkAll("preReset");
    tick();
    reset = 1'b1;
    clearModel();
    checkAll("midReset");
    check("midReset.stall", 64'(stall_req), 64'd0);
    check("midReset.slot_dest", 64'(slot_dest), 64'd0);
`ifdef SCOREBOARD_PERF_EN
    check("midReset.perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif
    tick();
    reset = 1'b0;

    // Randomized traffic over a small register range to provoke matches and hazards.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        tAddr[p] = REG_AW'($urandom_range(0, 5));
        tNeed[p] = SW'($urandom_range(0, 3));
        tGrf[p]  = $urandom;
      end
      for (int i = 0; i < STAGES; i++) tSlotVal[i] = $urandom;
      slot_value_valid = STAGES'($urandom_range(0, 7));
      setIssue(($urandom_range(0, 3) != 0), $urandom_range(0, 5), $urandom_range(0, 7));
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      checkAll($sformatf("rand%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
